nanov_digit_alu: RTL

Digit-serial integer ALU for nanoV, generalising the single-bit serial ALU to a configurable digit width with its own sequencing. It processes one XLEN-bit operation as XLEN/DIGIT digits, streamed LSB-first. It keeps the carry and digit count internally and produces the final SLT/SLTU/equality flags itself, so the core no longer tracks the last cycle. It sits between the register-file read shifters and the writeback shifter.

---
 rtl/nanov_digit_alu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/nanov_digit_alu.sv
`default_nettype none
// ============================================================================
//  Module      : nanov_digit_alu
//  Description : Digit-serial integer ALU for nanoV. Streams one XLEN-bit
//                operation as XLEN/DIGIT digits, LSB-first, keeping carry and
//                digit count internally and producing SLT/SLTU flags itself.
//                Optional equality flag: define NANOV_ALU_EQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module nanov_digit_alu #(
    parameter int XLEN  = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             in_valid,
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             busy,
    output logic             d_valid,
    output logic [DIGIT-1:0] d_dig,
    output logic             done,
    output logic             lt,
`ifdef NANOV_ALU_EQ_EN
    output logic             ltu,
    output logic             eq
`else
    output logic             ltu
`endif
);

    localparam int c_NDIG  = XLEN / DIGIT;
    localparam int c_CNT_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NDIG - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_op;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_count;

    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic               w_inv;
    logic [DIGIT-1:0]   w_b_eff;
    logic [DIGIT:0]     w_sum_full;
    logic               w_cout;
    logic [DIGIT-1:0]   w_result;

    assign busy     = (r_state == ST_RUN);
    assign w_start  = (r_state == ST_IDLE) && start;
    assign w_accept = (r_state == ST_RUN) && in_valid;
    assign w_last   = w_accept && (r_count == c_LAST);

    // SUB/SLT/SLTU subtract: B is inverted and the carry chain seeded with 1.
    assign w_inv      = r_op[3] | r_op[1];
    assign w_b_eff    = w_inv ? ~b_dig : b_dig;
    assign w_sum_full = {1'b0, a_dig} + {1'b0, w_b_eff} + {{DIGIT{1'b0}}, r_carry};
    assign w_cout     = w_sum_full[DIGIT];

    // Per-digit result selection from the latched op code.
    always_comb begin
        w_result = '0;
        case (r_op[2:0])
            3'b000:  w_result = w_sum_full[DIGIT-1:0];
            3'b111:  w_result = a_dig & b_dig;
            3'b110:  w_result = a_dig | b_dig;
            3'b100:  w_result = a_dig ^ b_dig;
            default: w_result = '0;
        endcase
    end

    // Next-state logic: IDLE waits for start, RUN ends on the last digit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operation context: op code, carry chain and digit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= 4'b0000;
            r_carry <= 1'b0;
            r_count <= '0;
        end else if (w_start) begin
            r_op    <= op;
            r_carry <= op[3] | op[1];
            r_count <= '0;
        end else if (w_accept) begin
            r_carry <= w_cout;
            r_count <= r_count + 1'b1;
        end
    end

    // Registered digit output, done pulse and final comparison flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid <= 1'b0;
            d_dig   <= '0;
            done    <= 1'b0;
            lt      <= 1'b0;
            ltu     <= 1'b0;
        end else begin
            d_valid <= w_accept;
            done    <= w_last;
            if (w_accept) d_dig <= w_result;
            if (w_start) begin
                lt  <= 1'b0;
                ltu <= 1'b0;
            end else if (w_last) begin
                ltu <= ~w_cout;
                lt  <= a_dig[DIGIT-1] ^ w_b_eff[DIGIT-1] ^ w_cout;
            end
        end
    end

`ifdef NANOV_ALU_EQ_EN
    logic r_eq_acc;

    // Equality accumulator across digits; published on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eq_acc <= 1'b0;
            eq       <= 1'b0;
        end else if (w_start) begin
            r_eq_acc <= 1'b1;
            eq       <= 1'b0;
        end else if (w_accept) begin
            r_eq_acc <= r_eq_acc & (a_dig == b_dig);
            if (w_last) eq <= r_eq_acc & (a_dig == b_dig);
        end
    end
`endif

endmodule
`default_nettype wire
